sm3_cmprss_core: RTL and testbench
==================================

Name: sm3_cmprss_core

Overview:
SM3 iterative compression engine (GB/T 32905-2016), one round per accepted beat.
- Sits after the message-expansion stage (pad -> expand -> compress).
- Consumes the expanded words W_j and W'_j for rounds 0..63 of each 512-bit block.
- Chains the 256-bit state V across blocks and emits the 256-bit digest after the last block of a message.

Parameters:
None. IV, T_j and round count (64) are fixed constants per GB/T 32905-2016.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
expnd_otpt_wj  input  32  expanded word W_j for the current round
expnd_otpt_wjj  input  32  expanded word W'_j = W_j ^ W_(j+4) for the current round
expnd_otpt_vld  input  1  beat valid; one round executed per valid cycle
expnd_otpt_lst  input  1  marks the round-63 beat of the message's final block
cmprss_otpt_res  output  256  digest {V0..V7}, V0 in bits [255:224]
cmprss_otpt_vld  output  1  one-cycle pulse, digest valid

Behaviour:
- One clock domain (clk). Reset is synchronous and active-low (rst_n); inputs are ignored while rst_n=0.
- Reset values:
  - V0..V7 and working registers A..H = IV: 7380166f 4914b2b9 172442d7 da8a0600 a96f30bc 163138aa e38dee4d b0fb0e4e.
  - Round counter j=0.
  - cmprss_otpt_vld=0, cmprss_otpt_res=0.
- Handshake:
  - No backpressure; every cycle with expnd_otpt_vld=1 is one round.
  - Gaps between valid beats are allowed; state holds while vld=0.
- Round j on a valid beat (all arithmetic mod 2^32; <<< is rotate left):
  - T = (j<16 ? 79cc4519 : 7a879d8a) <<< (j mod 32).
  - SS1 = ((A<<<12) + E + T) <<< 7; SS2 = SS1 ^ (A<<<12).
  - FF = j<16 ? A^B^C : (A&B)|(A&C)|(B&C).
  - GG = j<16 ? E^F^G : (E&F)|(~E&G).
  - TT1 = FF + D + SS2 + W'_j; TT2 = GG + H + SS1 + W_j.
  - Next state: D=C, C=B<<<9, B=A, A=TT1, H=G, G=F<<<19, F=E, E=P0(TT2), where P0(x)=x^(x<<<9)^(x<<<17).
  - j increments; it wraps 63 -> 0.
- Block end (valid beat with j=63):
  - Vnew = V ^ {A..H after round 63}, computed combinationally in the same cycle.
  - Register Vnew into V and into A..H, ready for the next block.
- Message end (j=63 beat with expnd_otpt_lst=1):
  - Next cycle: cmprss_otpt_res = Vnew and cmprss_otpt_vld = 1 for exactly one cycle.
  - V and A..H reload IV in that same edge, so the next message may start on the very next cycle with zero bubbles.
  - cmprss_otpt_res holds its value until the next digest or reset.
- expnd_otpt_lst on a beat with j≠63 is ignored (no state effect).
- Reset asserted mid-block aborts the message: state returns to IV, j=0, and no output pulse is produced.

Optional Feature:
SM3_CMPRSS_BLK_RES_OUT_EN
- Defined: cmprss_otpt_vld also pulses one cycle after every non-last block's j=63 beat, presenting the intermediate V on cmprss_otpt_res. An intermediate pulse leaves V chaining unchanged (no IV reload).
- Undefined: pulses occur only after the lst block.

Test Plan:
- Reset: hold rst_n=0 four cycles with random vld/W driven -> cmprss_otpt_vld=0 and res=0 throughout; first block after release uses the IV.
- 'abc' single block:
  - Stimulus: 64 back-to-back beats of the reference-model W/W', lst on beat 63.
  - Response: one vld pulse one cycle later with res = 66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0.
- 'abcd' x16 (512-bit message, two blocks):
  - Stimulus: 128 beats, lst only on the final beat.
  - Response: exactly one pulse, res = debe9ff92275b8a138604889c18e5a4d6fdb70e5387e5765293dcba39c0c5732.
- Gapped input: repeat the 'abc' test with vld randomly deasserted ~50% of cycles -> identical digest; pulse exactly one cycle after the final valid beat.
- Back-to-back messages and spurious lst:
  - Stimulus: 'abc' immediately followed by 'abcd' x16; additionally assert lst on a j=10 beat.
  - Response: two correct digests; the spurious lst has no effect.
- Reset mid-message and feature check:
  - Stimulus: pulse rst_n=0 at round 30, then resend 'abc'.
  - Response: correct digest, no earlier pulse.
  - With SM3_CMPRSS_BLK_RES_OUT_EN defined, the 'abcd' x16 run gives two pulses: the first carries the intermediate V after block 1, the second carries the final digest.

Source files
------------

// File: rtl/sm3_cmprss_core.sv
// SM3 iterative compression core: one round per valid beat, V chained across blocks.
// Optional macro SM3_CMPRSS_BLK_RES_OUT_EN also publishes the intermediate V after every non-final block.
module sm3_cmprss_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  expnd_otpt_wj,
  input  logic [31:0]  expnd_otpt_wjj,
  input  logic         expnd_otpt_vld,
  input  logic         expnd_otpt_lst,
  output logic [255:0] cmprss_otpt_res,
  output logic         cmprss_otpt_vld
);

  localparam logic [255:0] IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
  localparam logic [31:0]  T_LO = 32'h79cc4519;
  localparam logic [31:0]  T_HI = 32'h7a879d8a;

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
  endfunction

  // Working registers A..H packed with A in the top word, matching the digest layout.
  logic [255:0] st_q, st_d;
  logic [255:0] v_q, v_d;
  logic [255:0] res_q, res_d;
  logic [5:0]   j_q, j_d;
  logic         vld_q, vld_d;

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t_rot, a12, ss1, ss2, ff, gg, tt1, tt2;
  logic [255:0] rnd, vnew;
  logic        early;

  assign {a, b, c, d, e, f, g, h} = st_q;
  assign early = (j_q < 6'd16);

  always_comb begin
    t_rot = rotl(early ? T_LO : T_HI, j_q[4:0]);
    a12   = rotl(a, 5'd12);
    ss1   = rotl(a12 + e + t_rot, 5'd7);
    ss2   = ss1 ^ a12;
    ff    = early ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
    gg    = early ? (e ^ f ^ g) : ((e & f) | (~e & g));
    tt1   = ff + d + ss2 + expnd_otpt_wjj;
    tt2   = gg + h + ss1 + expnd_otpt_wj;
    rnd   = {tt1, a, rotl(b, 5'd9), c, p0(tt2), e, rotl(f, 5'd19), g};
    vnew  = v_q ^ rnd;
  end

  always_comb begin
    st_d  = st_q;
    v_d   = v_q;
    res_d = res_q;
    j_d   = j_q;
    vld_d = 1'b0;
    if (expnd_otpt_vld) begin
      j_d  = j_q + 6'd1;
      st_d = rnd;
      if (j_q == 6'd63) begin
        if (expnd_otpt_lst) begin
          // Reload IV on the same edge so the next message can start without a bubble.
          res_d = vnew;
          vld_d = 1'b1;
          v_d   = IV;
          st_d  = IV;
        end else begin
          v_d  = vnew;
          st_d = vnew;
`ifdef SM3_CMPRSS_BLK_RES_OUT_EN
          res_d = vnew;
          vld_d = 1'b1;
`else
          res_d = res_q;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= IV;
      v_q   <= IV;
      res_q <= '0;
      j_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      v_q   <= v_d;
      res_q <= res_d;
      j_q   <= j_d;
      vld_q <= vld_d;
    end
  end

  assign cmprss_otpt_res = res_q;
  assign cmprss_otpt_vld = vld_q;

endmodule

// File: tb/tb_sm3_cmprss_core.sv
// Self-checking bench for sm3_cmprss_core: pads and expands messages, drives W/W' beats,
// and compares digests against a full SM3 reference model (honours SM3_CMPRSS_BLK_RES_OUT_EN).
module tb_sm3_cmprss_core;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  wj = '0, wjj = '0;
  logic         vld = 1'b0, lst = 1'b0;
  logic [255:0] res;
  logic         ovld;

  sm3_cmprss_core dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .expnd_otpt_wj   (wj),
    .expnd_otpt_wjj  (wjj),
    .expnd_otpt_vld  (vld),
    .expnd_otpt_lst  (lst),
    .cmprss_otpt_res (res),
    .cmprss_otpt_vld (ovld)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] IV      = 256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;
  localparam logic [255:0] DIG_ABC = 256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0;
  localparam logic [255:0] DIG_ABCD16 = 256'hdebe9ff92275b8a138604889c18e5a4d6fdb70e5387e5765293dcba39c0c5732;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [255:0] got_res[$];
  int unsigned  got_cyc[$];
  always @(negedge clk) begin
    if (ovld === 1'b1) begin
      got_res.push_back(res);
      got_cyc.push_back(cyc);
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  byte unsigned msg_q[$];
  logic [31:0]  pw[$];
  logic [31:0]  W[68];
  logic [31:0]  Wp[64];
  logic [255:0] blkv[$];
  logic [255:0] exp_res[$];
  int unsigned  exp_cyc[$];
  int           beat_k;

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    int m;
    m = n % 32;
    if (m == 0) return x;
    return (x << m) | (x >> (32 - m));
  endfunction

  task automatic pad_msg();
    byte unsigned bq[$];
    longint unsigned bl;
    bl = longint'(msg_q.size()) * 8;
    bq = msg_q;
    bq.push_back(8'h80);
    while (bq.size() % 64 != 56) bq.push_back(8'h00);
    for (int i = 7; i >= 0; i--) bq.push_back(8'(bl >> (8 * i)));
    pw.delete();
    for (int i = 0; i < bq.size(); i += 4) pw.push_back({bq[i], bq[i+1], bq[i+2], bq[i+3]});
  endtask

  task automatic expand(input int blk);
    logic [31:0] x;
    for (int j = 0; j < 16; j++) W[j] = pw[16 * blk + j];
    for (int j = 16; j < 68; j++) begin
      x = W[j-16] ^ W[j-9] ^ rl(W[j-3], 15);
      W[j] = x ^ rl(x, 15) ^ rl(x, 23) ^ rl(W[j-13], 7) ^ W[j-6];
    end
    for (int j = 0; j < 64; j++) Wp[j] = W[j] ^ W[j+4];
  endtask

  task automatic compress_ref(inout logic [255:0] v);
    logic [31:0] r[8];
    logic [31:0] t, ss1, ss2, ff, gg, tt1, tt2;
    for (int i = 0; i < 8; i++) r[i] = v[255 - 32 * i -: 32];
    for (int j = 0; j < 64; j++) begin
      t   = rl((j < 16) ? 32'h79cc4519 : 32'h7a879d8a, j);
      ss1 = rl(rl(r[0], 12) + r[4] + t, 7);
      ss2 = ss1 ^ rl(r[0], 12);
      if (j < 16) begin
        ff = r[0] ^ r[1] ^ r[2];
        gg = r[4] ^ r[5] ^ r[6];
      end else begin
        ff = (r[0] & r[1]) | (r[0] & r[2]) | (r[1] & r[2]);
        gg = (r[4] & r[5]) | (~r[4] & r[6]);
      end
      tt1 = ff + r[3] + ss2 + Wp[j];
      tt2 = gg + r[7] + ss1 + W[j];
      r[3] = r[2]; r[2] = rl(r[1], 9); r[1] = r[0]; r[0] = tt1;
      r[7] = r[6]; r[6] = rl(r[5], 19); r[5] = r[4];
      r[4] = tt2 ^ rl(tt2, 9) ^ rl(tt2, 17);
    end
    for (int i = 0; i < 8; i++) v[255 - 32 * i -: 32] = v[255 - 32 * i -: 32] ^ r[i];
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    vld = 1'b0; lst = 1'($urandom); wj = $urandom; wjj = $urandom;
  endtask

  // Sends msg_q; abort_at >= 0 pulses reset instead of that global beat index.
  task automatic send_msg(input int gap_pct, input bit spur, input int abort_at);
    logic [255:0] v;
    int nblk;
    pad_msg();
    nblk = pw.size() / 16;
    blkv.delete();
    v = IV;
    for (int b = 0; b < nblk; b++) begin
      expand(b);
      compress_ref(v);
      blkv.push_back(v);
    end
    beat_k = 0;
    for (int b = 0; b < nblk; b++) begin
      expand(b);
      for (int j = 0; j < 64; j++) begin
        while ($urandom_range(99) < gap_pct) idle_cycle();
        @(posedge clk); #1;
        if (beat_k == abort_at) begin
          rst_n = 1'b0; vld = 1'b1; lst = 1'b1; wj = $urandom; wjj = $urandom;
          @(posedge clk); #1;
          rst_n = 1'b1; vld = 1'b0; lst = 1'b0;
          return;
        end
        vld = 1'b1; wj = W[j]; wjj = Wp[j];
        lst = ((b == nblk - 1) && (j == 63)) || (spur && b == 0 && j == 10);
        if (j == 63) begin
          if (b == nblk - 1) begin
            exp_res.push_back(blkv[b]); exp_cyc.push_back(cyc + 1);
          end
`ifdef SM3_CMPRSS_BLK_RES_OUT_EN
          else begin
            exp_res.push_back(blkv[b]); exp_cyc.push_back(cyc + 1);
          end
`endif
        end
        beat_k++;
      end
    end
  endtask

  task automatic start_test();
    got_res.delete(); got_cyc.delete(); exp_res.delete(); exp_cyc.delete();
  endtask

  task automatic set_abc();
    msg_q = '{8'h61, 8'h62, 8'h63};
  endtask

  task automatic set_abcd16();
    msg_q.delete();
    for (int i = 0; i < 16; i++) begin
      msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63); msg_q.push_back(8'h64);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1; vld = 1'($urandom); lst = 1'($urandom); wj = $urandom; wjj = $urandom;
      @(negedge clk);
      n_chk++;
      if (ovld !== 1'b0) $display("FAIL reset_vld cyc%0d: got %b want 0", i, ovld);
      else n_pass++;
      n_chk++;
      if (res !== 256'd0) $display("FAIL reset_res cyc%0d: got %h want 0", i, res);
      else n_pass++;
      @(posedge clk);
    end
    #1; rst_n = 1'b1; vld = 1'b0; lst = 1'b0;
  endtask

  task automatic test_abc();
    start_test();
    set_abc();
    send_msg(0, 1'b0, -1);
    repeat (4) idle_cycle();
    n_chk++;
    if (got_res.size() != exp_res.size()) $display("FAIL abc_count: got %0d pulses want %0d", got_res.size(), exp_res.size());
    else n_pass++;
    for (int i = 0; i < exp_res.size() && i < got_res.size(); i++) begin
      n_chk++;
      if (got_res[i] !== exp_res[i]) $display("FAIL abc_res[%0d]: got %h want %h", i, got_res[i], exp_res[i]);
      else n_pass++;
      n_chk++;
      if (got_cyc[i] !== exp_cyc[i]) $display("FAIL abc_cyc[%0d]: got %0d want %0d", i, got_cyc[i], exp_cyc[i]);
      else n_pass++;
    end
    n_chk++;
    if (got_res.size() == 0 || got_res[got_res.size()-1] !== DIG_ABC)
      $display("FAIL abc_known: got %h want %h", (got_res.size() != 0) ? got_res[got_res.size()-1] : 256'd0, DIG_ABC);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (res !== DIG_ABC || ovld !== 1'b0) $display("FAIL abc_hold: got %h vld %b want %h vld 0", res, ovld, DIG_ABC);
    else n_pass++;
  endtask

  task automatic test_abcd16();
    start_test();
    set_abcd16();
    send_msg(0, 1'b0, -1);
    repeat (4) idle_cycle();
    n_chk++;
    if (got_res.size() != exp_res.size()) $display("FAIL abcd16_count: got %0d pulses want %0d", got_res.size(), exp_res.size());
    else n_pass++;
    for (int i = 0; i < exp_res.size() && i < got_res.size(); i++) begin
      n_chk++;
      if (got_res[i] !== exp_res[i]) $display("FAIL abcd16_res[%0d]: got %h want %h", i, got_res[i], exp_res[i]);
      else n_pass++;
      n_chk++;
      if (got_cyc[i] !== exp_cyc[i]) $display("FAIL abcd16_cyc[%0d]: got %0d want %0d", i, got_cyc[i], exp_cyc[i]);
      else n_pass++;
    end
    n_chk++;
    if (got_res.size() == 0 || got_res[got_res.size()-1] !== DIG_ABCD16)
      $display("FAIL abcd16_known: got %h want %h", (got_res.size() != 0) ? got_res[got_res.size()-1] : 256'd0, DIG_ABCD16);
    else n_pass++;
  endtask

  task automatic test_gapped();
    start_test();
    set_abc();
    send_msg(50, 1'b0, -1);
    repeat (4) idle_cycle();
    n_chk++;
    if (got_res.size() != exp_res.size()) $display("FAIL gap_count: got %0d pulses want %0d", got_res.size(), exp_res.size());
    else n_pass++;
    for (int i = 0; i < exp_res.size() && i < got_res.size(); i++) begin
      n_chk++;
      if (got_res[i] !== DIG_ABC) $display("FAIL gap_res[%0d]: got %h want %h", i, got_res[i], DIG_ABC);
      else n_pass++;
      n_chk++;
      if (got_cyc[i] !== exp_cyc[i]) $display("FAIL gap_cyc[%0d]: got %0d want %0d", i, got_cyc[i], exp_cyc[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    start_test();
    set_abc();
    send_msg(0, 1'b0, -1);
    set_abcd16();
    send_msg(0, 1'b1, -1);
    repeat (4) idle_cycle();
    n_chk++;
    if (got_res.size() != exp_res.size()) $display("FAIL b2b_count: got %0d pulses want %0d", got_res.size(), exp_res.size());
    else n_pass++;
    for (int i = 0; i < exp_res.size() && i < got_res.size(); i++) begin
      n_chk++;
      if (got_res[i] !== exp_res[i]) $display("FAIL b2b_res[%0d]: got %h want %h", i, got_res[i], exp_res[i]);
      else n_pass++;
      n_chk++;
      if (got_cyc[i] !== exp_cyc[i]) $display("FAIL b2b_cyc[%0d]: got %0d want %0d", i, got_cyc[i], exp_cyc[i]);
      else n_pass++;
    end
    n_chk++;
    if (got_res.size() == 0 || got_res[0] !== DIG_ABC) $display("FAIL b2b_first: got %h want %h",
        (got_res.size() != 0) ? got_res[0] : 256'd0, DIG_ABC);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    start_test();
    set_abc();
    send_msg(0, 1'b0, 30);
    repeat (2) idle_cycle();
    @(negedge clk);
    n_chk++;
    if (got_res.size() != 0 || res !== 256'd0) $display("FAIL midrst_abort: got %0d pulses res %h want 0 pulses res 0", got_res.size(), res);
    else n_pass++;
    send_msg(20, 1'b0, -1);
    repeat (4) idle_cycle();
    n_chk++;
    if (got_res.size() != 1) $display("FAIL midrst_count: got %0d pulses want 1", got_res.size());
    else n_pass++;
    for (int i = 0; i < exp_res.size() && i < got_res.size(); i++) begin
      n_chk++;
      if (got_res[i] !== DIG_ABC) $display("FAIL midrst_res[%0d]: got %h want %h", i, got_res[i], DIG_ABC);
      else n_pass++;
      n_chk++;
      if (got_cyc[i] !== exp_cyc[i]) $display("FAIL midrst_cyc[%0d]: got %0d want %0d", i, got_cyc[i], exp_cyc[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    start_test();
    for (int m = 0; m < 4; m++) begin
      msg_q.delete();
      for (int i = $urandom_range(140); i > 0; i--) msg_q.push_back(8'($urandom));
      send_msg(25, 1'($urandom), -1);
    end
    repeat (4) idle_cycle();
    n_chk++;
    if (got_res.size() != exp_res.size()) $display("FAIL rand_count: got %0d pulses want %0d", got_res.size(), exp_res.size());
    else n_pass++;
    for (int i = 0; i < exp_res.size() && i < got_res.size(); i++) begin
      n_chk++;
      if (got_res[i] !== exp_res[i]) $display("FAIL rand_res[%0d]: got %h want %h", i, got_res[i], exp_res[i]);
      else n_pass++;
      n_chk++;
      if (got_cyc[i] !== exp_cyc[i]) $display("FAIL rand_cyc[%0d]: got %0d want %0d", i, got_cyc[i], exp_cyc[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_abcd16();
    test_gapped();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
